// File: rtl/fifo_vc_out_if.sv
// Purpose: push/pop data interface between a MUX output lane and its fifo_vc_out.
// Master side (upstream/consumer logic) drives push, pop and data_in; the FIFO
// (slave) returns registered read data, valid_out, occupancy flags, error and pause.
interface fifo_vc_out_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  error;
  logic                  pause;

  modport master (
    output push, pop, data_in,
    input  data_out, valid_out, fifo_empty, fifo_full,
    input  almost_full, almost_empty, error, pause
  );

  modport slave (
    input  push, pop, data_in,
    output data_out, valid_out, fifo_empty, fifo_full,
    output almost_full, almost_empty, error, pause
  );
endinterface

// File: rtl/fifo_vc_out.sv
// Purpose: per-lane output FIFO behind the transaction-layer MUX, 2**ADDR_WIDTH words deep.
// Latency: pop -> data_out/valid_out one cycle; flags reflect the registered count.
// Backpressure: overflowing pushes are dropped and flagged; pause (FIFO_PAUSE_EN) throttles upstream.
//
// Ports: clk, reset_L (async active-low), init + umbral_alto/umbral_bajo (threshold
// latch while in INIT), bus (fifo_vc_out_if.slave: push/pop/data and status flags),
// state (one-hot FSM: RESET 00001, INIT 00010, IDLE 00100, ACTIVE 01000, ERROR 10000).
// Optional macro FIFO_PAUSE_EN: builds the hysteretic pause register; otherwise pause=0.
module fifo_vc_out #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  init,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  fifo_vc_out_if.slave          bus,
  output logic [4:0]            state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ALTO_RST = DEPTH_C - (ADDR_WIDTH+1)'(2);
  localparam logic [ADDR_WIDTH:0] BAJO_RST = (ADDR_WIDTH+1)'(1);

  typedef enum logic [4:0] {
    S_RESET  = 5'b00001,
    S_INIT   = 5'b00010,
    S_IDLE   = 5'b00100,
    S_ACTIVE = 5'b01000,
    S_ERROR  = 5'b10000
  } state_t;

  state_t                st_q, st_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   alto_q, bajo_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  valid_q;
  logic                  err_q, err_d;
  logic                  ops_en, wr_en, rd_en, ovf, udf;

  // Data path only runs once thresholds are settled; RESET/INIT ignore push/pop.
  assign ops_en = (st_q == S_IDLE) || (st_q == S_ACTIVE) || (st_q == S_ERROR);
  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign wr_en  = ops_en && bus.push && ((count_q < DEPTH_C) || bus.pop);
  assign rd_en  = ops_en && bus.pop && (count_q != '0);
  assign ovf    = ops_en && bus.push && !bus.pop && (count_q == DEPTH_C);
  assign udf    = ops_en && bus.pop && (count_q == '0);
  assign count_d = count_q + (ADDR_WIDTH+1)'(wr_en) - (ADDR_WIDTH+1)'(rd_en);

  always_comb begin
    st_d  = st_q;
    err_d = err_q;
    case (st_q)
      S_RESET: st_d = S_INIT;
      S_INIT: begin
        err_d = 1'b0;
        if (!init) st_d = S_IDLE;
      end
      S_IDLE, S_ACTIVE: begin
        if (init) begin
          st_d = S_INIT;
        end else if (ovf || udf) begin
          st_d  = S_ERROR;
          err_d = 1'b1;
        end else begin
          st_d = (count_d == '0) ? S_IDLE : S_ACTIVE;
        end
      end
      S_ERROR: begin
        // Sticky until init; the FIFO itself keeps moving data meanwhile.
        if (init) begin
          st_d  = S_INIT;
          err_d = 1'b0;
        end
      end
      default: st_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      st_q       <= S_RESET;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      alto_q     <= ALTO_RST;
      bajo_q     <= BAJO_RST;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      st_q    <= st_d;
      err_q   <= err_d;
      count_q <= count_d;
      valid_q <= rd_en;
      if (wr_en) begin
        mem[wr_ptr] <= bus.data_in;
        wr_ptr      <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_en) begin
        data_out_q <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + ADDR_WIDTH'(1);
      end
      if (st_q == S_INIT && init) begin
        alto_q <= umbral_alto;
        bajo_q <= umbral_bajo;
      end
    end
  end

`ifdef FIFO_PAUSE_EN
  logic pause_q;
  // Hysteresis on the post-update occupancy: set at/above alto, clear at/below bajo.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pause_q <= 1'b0;
    end else if (count_d >= alto_q) begin
      pause_q <= 1'b1;
    end else if (count_d <= bajo_q) begin
      pause_q <= 1'b0;
    end
  end
  assign bus.pause = pause_q;
`else
  assign bus.pause = 1'b0;
`endif

  assign state            = st_q;
  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_q;
  assign bus.error        = err_q;
  assign bus.fifo_empty   = (count_q == '0);
  assign bus.fifo_full    = (count_q == DEPTH_C);
  assign bus.almost_full  = (count_q >= alto_q);
  assign bus.almost_empty = (count_q <= bajo_q);

endmodule

// File: doc/fifo_vc_out.md
Name: fifo_vc_out

Overview:
- Per-lane output FIFO that sits directly downstream of the 4-port transaction-layer MUX. One instance per MUX output (Out0..Out3).
- Buffers 10-bit words ([9:8] class/dest, [7:0] payload) and presents them to the next stage through a registered pop interface.
- Provides full/empty/almost flags and a sticky error flag.
- Runs a one-hot control FSM in the same style as the MUX state input.

Parameters:
- DATA_WIDTH, 10, word width; matches MUX output width.
- ADDR_WIDTH, 3, address bits; depth = 2**ADDR_WIDTH = 8 words.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- init  in  1  while in INIT, latch thresholds; deassert to leave INIT.
- umbral_alto  in  ADDR_WIDTH+1  almost-full threshold (occupancy at or above it sets almost_full).
- umbral_bajo  in  ADDR_WIDTH+1  almost-empty threshold (occupancy at or below it sets almost_empty).
- push  in  1  write strobe for data_in.
- data_in  in  DATA_WIDTH  word from the MUX output.
- pop  in  1  read strobe.
- data_out  out  DATA_WIDTH  registered read data.
- valid_out  out  1  data_out holds a word popped in the previous cycle.
- fifo_empty  out  1  occupancy == 0.
- fifo_full  out  1  occupancy == depth.
- almost_full  out  1  occupancy >= latched umbral_alto.
- almost_empty  out  1  occupancy <= latched umbral_bajo.
- error  out  1  sticky overflow/underflow flag.
- pause  out  1  backpressure to upstream (see Optional Feature).
- state  out  5  one-hot FSM state.

Behaviour:
- Reset (reset_L low, asynchronous):
  - state=RESET (5'b00001); pointers and count=0.
  - data_out=0, valid_out=0, error=0, pause=0.
  - fifo_empty=1, fifo_full=0, almost_full=0, almost_empty=1.
  - Latched thresholds reset to alto=depth-2 (6) and bajo=1.
- FSM states: RESET 00001, INIT 00010, IDLE 00100, ACTIVE 01000, ERROR 10000.
  - RESET -> INIT on the first clk edge with reset_L high.
  - INIT: each cycle with init=1, latch umbral_alto/umbral_bajo. init=0 -> IDLE. push/pop are ignored in INIT.
  - IDLE (count==0): a push -> ACTIVE.
  - ACTIVE: count returning to 0 (pop of last word with no push) -> IDLE. Any overflow/underflow -> ERROR.
  - ERROR: FIFO keeps operating normally; error stays 1. Exit only via reset_L or init=1, which goes -> INIT and clears error.
  - IDLE/ACTIVE: init=1 -> INIT; contents are preserved.
- Write: when push=1 and (count<depth or pop=1), store data_in at wr_ptr; wr_ptr wraps modulo depth.
- Read: when pop=1 and count>0, data_out<=mem[rd_ptr] on the same edge and valid_out=1 for that one cycle; rd_ptr wraps. Latency from pop to data_out is 1 cycle. With no pop, valid_out=0 and data_out holds its last value.
- Simultaneous push and pop:
  - Non-empty FIFO: both happen, count unchanged.
  - Full FIFO: legal, no overflow.
  - Empty FIFO: the push is stored, the pop is an underflow.
- Overflow (push, full, no pop): word dropped, error<=1, next state ERROR.
- Underflow (pop, empty): no read, valid_out=0, error<=1, next state ERROR.
- Flag timing: all flags are combinational from the registered count and latched thresholds, so they are valid the cycle after the update.
- Count is ADDR_WIDTH+1 bits, range 0..depth.
- Reset mid-operation: asynchronous clear of all contents and flags, regardless of the current state.

Optional Feature:
- Macro: FIFO_PAUSE_EN.
- Defined: pause is registered with hysteresis toward the upstream MUX. It sets to 1 when next count >= umbral_alto and clears to 0 when next count <= umbral_bajo; otherwise it holds.
- Undefined: pause is tied to 0 and no hysteresis logic is built.

Test Plan:
- Reset release, init=1 with alto=6 and bajo=2 for 1 cycle, then init=0 -> state 00001 -> 00010 -> 00100; fifo_empty=1, almost_empty=1.
- Push 10'b0100000011 then 10'b1000000010, then pop twice -> data_out equals each word 1 cycle after its pop with valid_out=1; state ACTIVE then IDLE; fifo_empty=1.
- Push 8 words 10'h001..10'h008 -> fifo_full=1 and almost_full=1 from count 6. A 9th push 10'h3FF is dropped, error=1, state 10000. Popping 8 words returns 10'h001..10'h008 in order.
- Full FIFO, push 10'h155 with pop on the same cycle -> no error, count stays 8, data_out=oldest word. Later pops confirm 10'h155 is last out after wrap-around.
- Pop on empty -> valid_out=0, error=1, state ERROR. Then init=1 -> state INIT, error=0.
- With FIFO_PAUSE_EN, alto=6 and bajo=2: pause rises on the push reaching count 6 and stays 1 while popping down to 3. It falls on reaching count 2. Without the macro, pause=0 throughout.
